data_chk: RTL and testbench

//  AXI-Stream sink directly downstream of data_gen in the aximm_test2 bench chain.

---
 rtl/data_chk_if.sv | 12 +
 rtl/data_chk.sv | 129 ++++++++++++
 tb/tb_data_chk.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_chk_if.sv
// rtl/data_chk_if.sv - AXI-Stream beat interface feeding the data_chk sink
interface data_chk_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/data_chk.sv
// rtl/data_chk.sv - ap_ctrl_hs stream sink checking an incrementing pattern and tlast framing
module data_chk #(
    parameter int WIDTH = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [31:0]      size,
    input  logic [WIDTH-1:0] seed,
    input  logic             throttle_en,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    data_chk_if.slave        s_axis,
    output logic [31:0]      beat_count,
    output logic [31:0]      err_count,
    output logic [31:0]      first_err_idx,
    output logic             last_early,
    output logic             last_missing
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_size;
    logic [WIDTH-1:0] r_seed;
    logic             r_throttle;
    logic [7:0]       r_lfsr;
    logic [31:0]      r_beat_count;
    logic [31:0]      r_err_count;
    logic [31:0]      r_first_err_idx;
    logic             r_last_early;
    logic             r_last_missing;

    logic             w_tready;
    logic             w_accept;
    logic             w_is_last;
    logic             w_start;
    logic [WIDTH-1:0] w_expected;
    logic             w_mismatch;
    logic             w_lfsr_fb;

    assign w_start    = (r_state == S_IDLE) && ap_start;
    assign w_accept   = s_axis.tvalid && w_tready;
    assign w_is_last  = (r_beat_count == (r_size - 32'd1));
    assign w_expected = r_seed + r_beat_count[WIDTH-1:0];
    assign w_mismatch = (s_axis.tdata != w_expected);
    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (ap_start) w_state_nxt = (size == 32'd0) ? S_DONE : S_RUN;
            S_RUN:  if (w_accept && (s_axis.tlast || w_is_last)) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // tready is built from registered state only, never from the incoming beat
    always_comb begin
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        w_tready = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = ap_start;
            end
            S_RUN:  w_tready = ~r_throttle | r_lfsr[0];
            S_DONE: ap_done = 1'b1;
            default: ap_idle = 1'b0;
        endcase
    end

    assign s_axis.tready = w_tready;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_size          <= '0;
            r_seed          <= '0;
            r_throttle      <= 1'b0;
            r_lfsr          <= 8'hA5;
            r_beat_count    <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_last_early    <= 1'b0;
            r_last_missing  <= 1'b0;
        end else begin
            if (w_start) begin
                r_size          <= size;
                r_seed          <= seed;
                r_throttle      <= throttle_en;
                r_beat_count    <= '0;
                r_err_count     <= '0;
                r_first_err_idx <= '0;
                r_last_early    <= 1'b0;
                r_last_missing  <= 1'b0;
            end
            if (r_state == S_RUN) begin
                r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
                if (w_accept) begin
                    r_beat_count <= r_beat_count + 32'd1;
                    if (w_mismatch) begin
                        if (r_err_count == 32'd0) r_first_err_idx <= r_beat_count;
                        if (r_err_count != 32'hFFFF_FFFF) r_err_count <= r_err_count + 32'd1;
                    end
                    if (s_axis.tlast && !w_is_last) r_last_early <= 1'b1;
                    if (!s_axis.tlast && w_is_last) r_last_missing <= 1'b1;
                end
            end
        end
    end

    assign beat_count    = r_beat_count;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;
    assign last_early    = r_last_early;
    assign last_missing  = r_last_missing;
endmodule

// File: tb/tb_data_chk.sv
// tb/tb_data_chk.sv - randomized self-checking bench for data_chk against a beat-list model
module tb_data_chk;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [31:0] size;
    logic [7:0]  seed;
    logic        throttle_en;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] beat_count, err_count, first_err_idx;
    logic        last_early, last_missing;

    data_chk_if #(.WIDTH(8)) s_axis ();

    data_chk #(.WIDTH(8)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .size          (size),
        .seed          (seed),
        .throttle_en   (throttle_en),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .s_axis        (s_axis.slave),
        .beat_count    (beat_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .last_early    (last_early),
        .last_missing  (last_missing)
    );

    always #5 ap_clk = ~ap_clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q_data[$];
    bit         q_last[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic build_clean(input int n, input logic [7:0] sd, input int last_at);
        q_data.delete();
        q_last.delete();
        for (int i = 0; i < n; i++) begin
            q_data.push_back(8'(sd + 8'(i)));
            q_last.push_back(i == last_at);
        end
    endtask

    // Starts a run, streams q_data/q_last with random valid gaps, checks against the beat-list model
    task automatic drive_run(input string name, input logic [31:0] sz, input logic [7:0] sd,
                             input logic thr, input int gap);
        int idx, cyc, last_acc_cyc, done_cyc, ready_lows;
        bit acc, done_seen;
        logic [31:0] e_bc, e_err, e_first;
        bit e_early, e_missing;

        e_bc = 0; e_err = 0; e_first = 0; e_early = 0; e_missing = 0;
        if (sz != 0) begin
            for (int i = 0; i < q_data.size(); i++) begin
                if (q_data[i] != 8'(sd + 8'(i))) begin
                    if (e_err == 0) e_first = i;
                    e_err++;
                end
                e_bc = i + 1;
                if (q_last[i] && (i < int'(sz) - 1)) begin e_early = 1; break; end
                if (i == int'(sz) - 1) begin e_missing = !q_last[i]; break; end
            end
        end

        @(negedge ap_clk);
        size = sz; seed = sd; throttle_en = thr; ap_start = 1'b1;
        #1;
        vectors++;
        if (ap_ready !== 1'b1 || ap_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL %s start: ap_ready=%b ap_idle=%b expected 1 1", name, ap_ready, ap_idle);
        end
        @(negedge ap_clk);
        ap_start = 1'b0;
        size = $urandom; seed = 8'($urandom); throttle_en = 1'($urandom);

        idx = 0; cyc = 0; last_acc_cyc = 0; done_cyc = -1; ready_lows = 0; done_seen = 0;
        while (!done_seen && cyc < 3000) begin
            if (ap_done === 1'b1) begin
                done_seen = 1;
                done_cyc = cyc;
            end else begin
                if (s_axis.tready !== 1'b1) ready_lows++;
                if (idx < q_data.size() && $urandom_range(99) >= gap) begin
                    s_axis.tvalid = 1'b1;
                    s_axis.tdata  = q_data[idx];
                    s_axis.tlast  = q_last[idx];
                end else begin
                    s_axis.tvalid = 1'b0;
                    s_axis.tdata  = 8'($urandom);
                    s_axis.tlast  = 1'($urandom);
                end
                #1 acc = s_axis.tvalid && s_axis.tready;
                @(negedge ap_clk);
                cyc++;
                if (acc) begin idx++; last_acc_cyc = cyc; end
            end
        end
        s_axis.tvalid = 1'b0;

        vectors++;
        if (!done_seen) begin
            miscompares++;
            $display("FAIL %s done_timeout: no ap_done after %0d cycles", name, cyc);
        end
        chk({name, " done_latency"}, 32'(done_cyc), 32'(last_acc_cyc));
        chk({name, " tready_in_done"}, 32'(s_axis.tready), 32'd0);
        chk({name, " accepted"}, 32'(idx), e_bc);
        chk({name, " beat_count"}, beat_count, e_bc);
        chk({name, " err_count"}, err_count, e_err);
        if (e_err != 0) chk({name, " first_err_idx"}, first_err_idx, e_first);
        chk({name, " last_early"}, 32'(last_early), 32'(e_early));
        chk({name, " last_missing"}, 32'(last_missing), 32'(e_missing));
        if (!thr) chk({name, " unthrottled_lows"}, 32'(ready_lows), 32'd0);
        if (thr && e_bc >= 16) begin
            vectors++;
            if (ready_lows == 0) begin
                miscompares++;
                $display("FAIL %s throttle: tready never low, expected some low cycles", name);
            end
        end
        @(negedge ap_clk);
        chk({name, " done_pulse_width"}, 32'(ap_done), 32'd0);
        chk({name, " idle_after"}, 32'(ap_idle), 32'd1);
        chk({name, " hold_beat_count"}, beat_count, e_bc);
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b0; ap_start = 1'b0; size = 0; seed = 0; throttle_en = 0;
        s_axis.tvalid = 1'b0; s_axis.tdata = 0; s_axis.tlast = 0;
        repeat (2) @(negedge ap_clk);
        chk("reset ap_idle", 32'(ap_idle), 32'd1);
        chk("reset ap_done", 32'(ap_done), 32'd0);
        chk("reset tready", 32'(s_axis.tready), 32'd0);
        chk("reset beat_count", beat_count, 32'd0);
        chk("reset err_count", err_count, 32'd0);
        chk("reset flags", {30'd0, last_early, last_missing}, 32'd0);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_clean;
        build_clean(20, 8'h10, 15);
        drive_run("clean", 32'd16, 8'h10, 1'b0, 0);
    endtask

    task automatic test_throttle;
        build_clean(100, 8'hF0, 99);
        drive_run("throttle", 32'd100, 8'hF0, 1'b1, 20);
    endtask

    task automatic test_errors;
        build_clean(8, 8'h00, 7);
        q_data[5] = 8'hAA;
        q_data[6] = 8'hBB;
        drive_run("errors", 32'd8, 8'h00, 1'b0, 0);
    endtask

    task automatic test_framing;
        build_clean(8, 8'h33, 3);
        drive_run("last_early", 32'd8, 8'h33, 1'b0, 0);
        build_clean(6, 8'h77, -1);
        drive_run("last_missing", 32'd4, 8'h77, 1'b1, 0);
    endtask

    task automatic test_zero;
        build_clean(4, 8'h00, 3);
        drive_run("size_zero", 32'd0, 8'h00, 1'b0, 0);
    endtask

    task automatic test_reset_mid_run;
        @(negedge ap_clk);
        size = 32'd20; seed = 8'h40; throttle_en = 1'b0; ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_axis.tvalid = 1'b1; s_axis.tdata = 8'(8'h40 + 8'(i)); s_axis.tlast = 1'b0;
            @(negedge ap_clk);
        end
        s_axis.tvalid = 1'b0;
        chk("midrun beat_count_pre", beat_count, 32'd7);
        ap_rst_n = 1'b0;
        #1;
        chk("midrun tready", 32'(s_axis.tready), 32'd0);
        chk("midrun ap_idle", 32'(ap_idle), 32'd1);
        chk("midrun beat_count", beat_count, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        build_clean(20, 8'hC3, 19);
        drive_run("after_reset", 32'd20, 8'hC3, 1'b0, 10);
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            int n, last_at;
            logic [7:0] sd;
            n = $urandom_range(40, 1);
            sd = 8'($urandom);
            last_at = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : n - 1;
            build_clean(n + 3, sd, last_at);
            for (int k = 0; k < n + 3; k++)
                if ($urandom_range(9) == 0) q_data[k] = 8'($urandom);
            if ($urandom_range(4) == 0) q_last[n - 1] = 1'b0;
            drive_run("random", 32'(n), sd, 1'($urandom), 30);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_throttle();
        test_errors();
        test_framing();
        test_zero();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
